// File: rtl/sprite_capture.sv
// sprite_capture: writes a WIDTH x HEIGHT window of one camera frame into the
// sprite image BRAM, one RGB332 word per in-window pixel, raster addressed
// (addr = column + row*WIDTH). One capture per trigger, aligned to frame start.
module sprite_capture #(
  parameter int WIDTH  = 256,
  parameter int HEIGHT = 256
) (
  input  logic                              pixel_clk_in,
  input  logic                              rst_in,
  input  logic [10:0]                       x_in,
  input  logic [9:0]                        y_in,
  input  logic [10:0]                       hcount_in,
  input  logic [9:0]                        vcount_in,
  input  logic                              pixel_valid_in,
  input  logic [15:0]                       pixel_in,
  input  logic                              capture_in,
  output logic [$clog2(WIDTH*HEIGHT)-1:0]   addr_out,
  output logic [7:0]                        data_out,
  output logic                              we_out,
  output logic                              busy_out,
  output logic                              done_out,
  output logic                              incomplete_out
);

  localparam int AW    = $clog2(WIDTH*HEIGHT);
  localparam int TOTAL = WIDTH * HEIGHT;
  localparam logic [AW:0] LAST = (AW+1)'(TOTAL - 1);

  typedef enum logic [1:0] {IDLE, ARMED, CAPTURE} state_t;

  // one BRAM write beat
  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [7:0]    data;
  } wr_t;

  state_t      state, state_n;
  logic [10:0] xl;
  logic [9:0]  yl;
  logic        latch;
  logic [AW:0] cnt, cnt_n, cnt_cur;
  wr_t         wr_n;
  logic        done_n, inc_n;

  logic        fs, in_win, take;
  logic [11:0] x_end;
  logic [10:0] y_end;
  logic [10:0] hdiff;
  logic [9:0]  vdiff;
  logic [AW-1:0] addr_calc;
  logic [7:0]  rgb332;
  logic        unused_bits;

  assign fs     = pixel_valid_in && (hcount_in == 11'd0) && (vcount_in == 10'd0);

  // widened sums so a window near the screen edge never wraps back in range
  assign x_end  = {1'b0, xl} + 12'(WIDTH);
  assign y_end  = {1'b0, yl} + 11'(HEIGHT);
  assign in_win = pixel_valid_in
                  && (hcount_in >= xl) && ({1'b0, hcount_in} < x_end)
                  && (vcount_in >= yl) && ({1'b0, vcount_in} < y_end);

  assign hdiff     = hcount_in - xl;
  assign vdiff     = vcount_in - yl;
  assign addr_calc = AW'(hdiff) + AW'(32'(vdiff) * 32'(WIDTH));

  // RGB565 -> RGB332: keep the top bits of each channel
  assign rgb332      = {pixel_in[15:13], pixel_in[10:8], pixel_in[4:3]};
  assign unused_bits = ^{pixel_in[12:11], pixel_in[7:5], pixel_in[2:0]};

  // the entry fs is a capture pixel with a freshly cleared counter;
  // any later fs in CAPTURE ends the frame instead of writing
  assign take    = ((state == ARMED) && fs) || ((state == CAPTURE) && !fs);
  assign cnt_cur = (state == ARMED) ? '0 : cnt;

  // state register
  always_ff @(posedge pixel_clk_in or posedge rst_in) begin
    if (rst_in) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  // window origin, captured only on an accepted trigger
  always_ff @(posedge pixel_clk_in or posedge rst_in) begin
    if (rst_in) begin
      xl <= '0;
      yl <= '0;
    end else if (latch) begin
      xl <= x_in;
      yl <= y_in;
    end
  end

  // next state, write beat and completion pulses
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    latch     = 1'b0;
    wr_n.we   = 1'b0;
    wr_n.addr = addr_out;
    wr_n.data = data_out;
    done_n    = 1'b0;
    inc_n     = 1'b0;
    case (state)
      IDLE: begin
        if (capture_in) begin
          latch   = 1'b1;
          cnt_n   = '0;
          state_n = ARMED;
        end
      end
      ARMED: begin
        cnt_n = '0;
        if (fs) state_n = CAPTURE;
      end
      CAPTURE: begin
        if (fs) begin
          done_n  = 1'b1;
          inc_n   = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
    if (take && in_win) begin
      wr_n.we   = 1'b1;
      wr_n.addr = addr_calc;
      wr_n.data = rgb332;
      cnt_n     = cnt_cur + 1'b1;
      if (cnt_cur == LAST) begin
        done_n  = 1'b1;
        state_n = IDLE;
      end
    end
  end

  // registered outputs; busy follows the next state so it drops with done
  always_ff @(posedge pixel_clk_in or posedge rst_in) begin
    if (rst_in) begin
      we_out         <= 1'b0;
      addr_out       <= '0;
      data_out       <= '0;
      busy_out       <= 1'b0;
      done_out       <= 1'b0;
      incomplete_out <= 1'b0;
    end else begin
      we_out         <= wr_n.we;
      addr_out       <= wr_n.addr;
      data_out       <= wr_n.data;
      busy_out       <= (state_n != IDLE);
      done_out       <= done_n;
      incomplete_out <= inc_n;
    end
  end

endmodule

// File: tb/tb_sprite_capture.sv
// Directed bench for sprite_capture with a 4x2 window over an 8x4 frame.
module tb_sprite_capture;

  localparam int W  = 4;
  localparam int H  = 2;
  localparam int AW = $clog2(W*H);

  logic          clk = 1'b0;
  logic          rst;
  logic [10:0]   x_in, hcount;
  logic [9:0]    y_in, vcount;
  logic          pixel_valid, capture;
  logic [15:0]   pixel;
  logic [AW-1:0] addr;
  logic [7:0]    data;
  logic          we, busy, done, inc;

  int total = 0;
  int bad   = 0;

  sprite_capture #(.WIDTH(W), .HEIGHT(H)) dut (
    .pixel_clk_in   (clk),
    .rst_in         (rst),
    .x_in           (x_in),
    .y_in           (y_in),
    .hcount_in      (hcount),
    .vcount_in      (vcount),
    .pixel_valid_in (pixel_valid),
    .pixel_in       (pixel),
    .capture_in     (capture),
    .addr_out       (addr),
    .data_out       (data),
    .we_out         (we),
    .busy_out       (busy),
    .done_out       (done),
    .incomplete_out (inc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // one pixel cycle; afterwards the outputs reflect this pixel
  task automatic step(input int h, input int v, input logic [15:0] p,
                      input logic vld, input logic cap);
    hcount      = 11'(h);
    vcount      = 10'(v);
    pixel       = p;
    pixel_valid = vld;
    capture     = cap;
    @(posedge clk);
    #1;
    pixel_valid = 1'b0;
    capture     = 1'b0;
  endtask

  task automatic chk_wr(input string tag, input logic e_we, input int e_addr,
                        input int e_data, input logic e_done, input logic e_inc);
    chk({tag, ".we"}, 32'(we), 32'(e_we));
    if (e_we) begin
      chk({tag, ".addr"}, 32'(addr), 32'(e_addr));
      chk({tag, ".data"}, 32'(data), 32'(e_data));
    end
    chk({tag, ".done"}, 32'(done), 32'(e_done));
    chk({tag, ".inc"},  32'(inc),  32'(e_inc));
  endtask

  initial begin
    logic inw;
    logic [7:0] hb, vb;
    rst = 1'b1; x_in = '0; y_in = '0; hcount = '0; vcount = '0;
    pixel_valid = 1'b0; capture = 1'b0; pixel = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.we", 32'(we), 0);
    chk("rst.addr", 32'(addr), 0);
    chk("rst.data", 32'(data), 0);
    chk("rst.busy", 32'(busy), 0);
    chk("rst.done", 32'(done), 0);
    chk("rst.inc", 32'(inc), 0);
    rst = 1'b0;
    step(0, 0, 16'h0, 1'b0, 1'b0);

    // basic capture, window at (2,1), pixel = {h,v}; data is h<<2
    x_in = 11'd2; y_in = 10'd1;
    step(0, 0, 16'h0, 1'b0, 1'b1);
    chk("basic.busy_rise", 32'(busy), 1);
    for (int v = 0; v < 4; v++) begin
      for (int h = 0; h < 8; h++) begin
        hb = 8'(h); vb = 8'(v);
        step(h, v, {hb, vb}, 1'b1, 1'b0);
        inw = (h >= 2) && (h < 6) && (v >= 1) && (v < 3);
        chk_wr($sformatf("basic(%0d,%0d)", h, v), inw, (h - 2) + (v - 1) * 4,
               h * 4, (h == 5) && (v == 2), 1'b0);
        chk($sformatf("basic.busy(%0d,%0d)", h, v), 32'(busy),
            32'(!((v > 2) || ((v == 2) && (h >= 5)))));
      end
    end
    step(0, 0, 16'hFFFF, 1'b1, 1'b0);
    chk_wr("basic.idle_fs", 1'b0, 0, 0, 1'b0, 1'b0);

    // colour conversion, retrigger/x_in change while armed, valid gaps
    x_in = 11'd0; y_in = 10'd0;
    step(5, 3, 16'h0, 1'b0, 1'b1);
    x_in = 11'd5; y_in = 10'd2;
    step(3, 3, 16'hFFFF, 1'b1, 1'b1);
    chk_wr("col.armed", 1'b0, 0, 0, 1'b0, 1'b0);
    step(0, 0, 16'hF800, 1'b1, 1'b0);
    chk_wr("col.red", 1'b1, 0, 8'hE0, 1'b0, 1'b0);
    step(1, 0, 16'h07E0, 1'b1, 1'b0);
    chk_wr("col.green", 1'b1, 1, 8'h1C, 1'b0, 1'b0);
    step(2, 0, 16'h001F, 1'b1, 1'b0);
    chk_wr("col.blue", 1'b1, 2, 8'h03, 1'b0, 1'b0);
    step(3, 0, 16'hFFFF, 1'b1, 1'b0);
    chk_wr("col.white", 1'b1, 3, 8'hFF, 1'b0, 1'b0);
    step(4, 0, 16'hFFFF, 1'b1, 1'b0);
    chk_wr("col.outside", 1'b0, 0, 0, 1'b0, 1'b0);
    chk("col.hold_addr", 32'(addr), 3);
    chk("col.hold_data", 32'(data), 8'hFF);
    step(0, 1, 16'hFFFF, 1'b0, 1'b0);
    chk_wr("col.gap0", 1'b0, 0, 0, 1'b0, 1'b0);
    step(0, 1, 16'h0000, 1'b1, 1'b0);
    chk_wr("col.r1c0", 1'b1, 4, 8'h00, 1'b0, 1'b0);
    step(1, 1, 16'h0000, 1'b0, 1'b0);
    chk_wr("col.gap1", 1'b0, 0, 0, 1'b0, 1'b0);
    step(1, 1, 16'hFFFF, 1'b1, 1'b0);
    chk_wr("col.r1c1", 1'b1, 5, 8'hFF, 1'b0, 1'b0);
    step(2, 1, 16'hF800, 1'b1, 1'b0);
    chk_wr("col.r1c2", 1'b1, 6, 8'hE0, 1'b0, 1'b0);
    step(3, 1, 16'h07E0, 1'b1, 1'b0);
    chk_wr("col.r1c3", 1'b1, 7, 8'h1C, 1'b1, 1'b0);
    chk("col.busy_fall", 32'(busy), 0);

    // mid-frame trigger waits for fs, then reset after three writes
    x_in = 11'd0; y_in = 10'd0;
    step(3, 1, 16'hFFFF, 1'b1, 1'b1);
    chk("mid.busy", 32'(busy), 1);
    chk("mid.we0", 32'(we), 0);
    step(4, 1, 16'hFFFF, 1'b1, 1'b0);
    chk("mid.we1", 32'(we), 0);
    step(0, 2, 16'hFFFF, 1'b1, 1'b0);
    chk("mid.we2", 32'(we), 0);
    step(0, 0, 16'hF800, 1'b1, 1'b0);
    chk_wr("mid.w0", 1'b1, 0, 8'hE0, 1'b0, 1'b0);
    step(1, 0, 16'h07E0, 1'b1, 1'b0);
    chk_wr("mid.w1", 1'b1, 1, 8'h1C, 1'b0, 1'b0);
    step(2, 0, 16'h001F, 1'b1, 1'b0);
    chk_wr("mid.w2", 1'b1, 2, 8'h03, 1'b0, 1'b0);
    rst = 1'b1;
    #1;
    chk("rst2.we", 32'(we), 0);
    chk("rst2.addr", 32'(addr), 0);
    chk("rst2.data", 32'(data), 0);
    chk("rst2.busy", 32'(busy), 0);
    chk("rst2.done", 32'(done), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    step(2, 2, 16'h0, 1'b0, 1'b1);
    chk("re.busy", 32'(busy), 1);
    step(1, 0, 16'hFFFF, 1'b1, 1'b0);
    chk_wr("re.armed", 1'b0, 0, 0, 1'b0, 1'b0);
    step(0, 0, 16'hFFFF, 1'b1, 1'b0);
    chk_wr("re.w0", 1'b1, 0, 8'hFF, 1'b0, 1'b0);
    step(1, 0, 16'h001F, 1'b1, 1'b0);
    chk_wr("re.w1", 1'b1, 1, 8'h03, 1'b0, 1'b0);
    step(0, 0, 16'h0000, 1'b1, 1'b0);
    chk_wr("re.early_fs", 1'b0, 0, 0, 1'b1, 1'b1);
    chk("re.busy_fall", 32'(busy), 0);

    // window hanging off the right edge: only columns 6,7 land
    x_in = 11'd6; y_in = 10'd0;
    step(0, 3, 16'h0, 1'b0, 1'b1);
    for (int v = 0; v < 4; v++) begin
      for (int h = 0; h < 8; h++) begin
        step(h, v, 16'hFFFF, 1'b1, 1'b0);
        inw = (h >= 6) && (v < 2);
        chk_wr($sformatf("off(%0d,%0d)", h, v), inw, (h - 6) + v * 4,
               8'hFF, 1'b0, 1'b0);
      end
    end
    step(0, 0, 16'hFFFF, 1'b1, 1'b0);
    chk_wr("off.fs_end", 1'b0, 0, 0, 1'b1, 1'b1);
    chk("off.busy", 32'(busy), 0);
    step(0, 0, 16'h0, 1'b0, 1'b1);
    chk("done_cycle_trig.busy", 32'(busy), 1);
    chk("done_cycle_trig.done", 32'(done), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
